display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

- Time-multiplexed scan controller for the 8-digit seven-segment display.
- Generates the 3-bit digit select and enable that drive the 3-to-8 digit/anode decoder directly downstream.
- Presents the 4-bit hex nibble for the digit currently selected, for the segment encoder.
- Double-buffers the displayed 32-bit value so updates take effect only at frame boundaries, which prevents tearing.

## Interface
Parameters:
- PRESCALE, 1000: clock cycles per digit slot; must be ≥ BLANK_CYCLES+1.
- BLANK_CYCLES, 4: anti-ghosting guard; cycles at the start of each slot with enable forced low; must be ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  single-cycle request to capture value_in.
- value_in  in  32  new display value; nibble [31:28] is the leftmost digit.
- blank_lz  in  1  leading-zero blanking enable, sampled every cycle.
- sel  out  3  digit index, connects to the decoder select input; 0 = leftmost digit (decoder output bit 7).
- sel_en  out  1  connects to the decoder enable input.
- nibble  out  4  hex value of digit sel.
- pending  out  1  a loaded value is waiting for the frame boundary.
- frame_done  out  1  one-cycle pulse on the first cycle of each new frame.

## Operation
- Registers:
  - cnt: 0..PRESCALE-1.
  - sel: 0..7.
  - active: 32 bits, the value being shown.
  - shadow: 32 bits, pending value.
  - pending flag.
- Slot timer:
  - cnt increments every cycle.
  - When cnt==PRESCALE-1: cnt→0, and sel→sel+1, wrapping 7→0.
- Frame boundary is the cycle where the wrap 7→0 takes effect (sel becomes 0). On that cycle:
  - frame_done=1.
  - If pending: active←shadow and pending←0.
- Load:
  - load=1 captures value_in into shadow and sets pending.
  - A second load before the boundary overwrites shadow (last value wins).
  - Load on the same cycle the boundary is registered: value_in goes directly to active, and pending stays/returns 0.
- nibble = active[31-4·sel -: 4].
- Leading-zero blank for digit k (k<7): blank_lz=1 and nibbles 0..k of active are all zero.
  - Digit 7 is never blanked, so a zero value shows "0".
- sel_en=1 iff cnt ≥ BLANK_CYCLES and the current digit is not blanked.
- Slot states: GUARD (cnt<BLANK_CYCLES, en=0) → SHOW (en per blanking) → GUARD of the next digit.
- Reset values: cnt=0, sel=0, sel_en=0, nibble=0, active=0, shadow=0, pending=0, frame_done=0.
  - Reset mid-frame discards both the active and pending values.
  - Scanning restarts at digit 0 in GUARD.

## Timing
- All outputs are registered or derived only from registers; there are no combinational paths from inputs to outputs.
  - Exception: blank_lz feeds sel_en with at most one cycle of delay, which must be registered.
- Slot length is exactly PRESCALE cycles; frame length is 8·PRESCALE cycles.
- sel_en never rises in the same cycle that sel changes. At least BLANK_CYCLES low cycles follow every sel change.
- Load-to-display latency: from 1 cycle (load coincident with boundary) up to 8·PRESCALE cycles.
- pending rises the cycle after load. It falls on the cycle active updates (the frame_done cycle).
- The first frame_done after reset occurs 8·PRESCALE cycles after rst deasserts.

## Structure
- Shared include file holds:
  - DIGITS=8, SEL_W=3, NIB_W=4.
  - The default PRESCALE and BLANK_CYCLES for the board clock.
- One sub-module, slot_timer:
  - Parameterized modulo-PRESCALE counter.
  - Outputs cnt, a wrap pulse, and an in_guard flag.
- Top level contains the sel counter, the double buffer, the blank logic, and the nibble mux.

## Test plan
Use PRESCALE=4, BLANK_CYCLES=1 unless noted.

1. Reset then idle:
   - sel steps 0,1,…,7,0 every 4 cycles.
   - sel_en pattern per slot is 0,1,1,1 (blank_lz=0).
   - frame_done pulses at cycle 32 after reset.
2. Load 32'h1234ABCD mid-frame:
   - pending=1 until the boundary; nibble holds 0 until then.
   - Next frame shows nibble 1,2,3,4,A,B,C,D for sel 0..7.
   - frame_done and the pending fall coincide.
3. Leading-zero blanking, blank_lz=1, load 32'h0000_0F00:
   - sel_en=0 for sel 0..4.
   - Digits 5,6,7 enabled, showing F,0,0.
   - Load 0: only sel 7 is enabled, showing 0.
4. Double load:
   - Load 32'h11111111, then 32'h22222222 before the boundary.
   - Next frame shows 2s only.
   - Load asserted exactly on the boundary cycle: value appears that frame, and pending stays 0.
5. Mid-operation reset:
   - Assert rst with sel=5 and pending=1.
   - Next cycle: sel=0, sel_en=0, pending=0, nibble=0.
   - The held value is not displayed afterward.
6. Parameter sweep, PRESCALE=1000, BLANK_CYCLES=4:
   - Slot is 1000 cycles and the guard is 4 cycles.
   - sel_en is never high in the cycle sel changes (assertion checked over 3 frames).

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared constants and helpers for the 8-digit seven-segment scan controller.
// Holds the board-clock defaults for slot length and the anti-ghosting guard.
package display_scan_ctrl_pkg;

    localparam int DIGITS           = 8;
    localparam int SEL_W            = 3;
    localparam int NIB_W            = 4;
    localparam int VAL_W            = DIGITS * NIB_W;
    localparam int DEF_PRESCALE     = 1000;
    localparam int DEF_BLANK_CYCLES = 4;

    typedef enum logic {
        SLOT_GUARD = 1'b0,
        SLOT_SHOW  = 1'b1
    } slot_state_e;

    // Digit 0 is the leftmost digit, held in the most significant nibble.
    function automatic logic [NIB_W-1:0] digit_nibble(
        input logic [VAL_W-1:0] v,
        input logic [SEL_W-1:0] k
    );
        logic [NIB_W-1:0] n;
        n = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (k == SEL_W'(i)) begin
                n = v[VAL_W-1-NIB_W*i -: NIB_W];
            end
        end
        return n;
    endfunction

    // True when digit k and every digit to its left are zero; the last digit never blanks.
    function automatic logic lz_blanked(
        input logic [VAL_W-1:0] v,
        input logic [SEL_W-1:0] k
    );
        logic all_zero;
        all_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (SEL_W'(i) <= k) begin
                all_zero = all_zero & (v[VAL_W-1-NIB_W*i -: NIB_W] == '0);
            end
        end
        return all_zero && (k != SEL_W'(DIGITS-1));
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Load/value/blanking inputs and scan outputs of the display scan controller.
// The master drives display updates; the slave is the controller itself.
interface display_scan_ctrl_if;
    import display_scan_ctrl_pkg::*;

    logic             load;
    logic [VAL_W-1:0] value_in;
    logic             blank_lz;
    logic [SEL_W-1:0] sel;
    logic             sel_en;
    logic [NIB_W-1:0] nibble;
    logic             pending;
    logic             frame_done;

    modport master (
        output load, value_in, blank_lz,
        input  sel, sel_en, nibble, pending, frame_done
    );

    modport slave (
        input  load, value_in, blank_lz,
        output sel, sel_en, nibble, pending, frame_done
    );

endinterface

// File: rtl/display_scan_ctrl_slot_timer.sv
// Modulo-PRESCALE slot counter with a GUARD/SHOW phase tracker per digit slot.
// Free-running, no backpressure; wrap is high on the last cycle of a slot.
module slot_timer
    import display_scan_ctrl_pkg::*;
#(
    parameter  int PRESCALE     = DEF_PRESCALE,
    parameter  int BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int CNT_W        = $clog2(PRESCALE)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             in_guard
);

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    slot_state_e      state_q, state_d;

    always_comb begin
        wrap    = (cnt_q == CNT_LAST);
        cnt_d   = wrap ? '0 : cnt_q + 1'b1;
        state_d = state_q;
        case (state_q)
            SLOT_GUARD: if (cnt_q == GUARD_LAST) state_d = SLOT_SHOW;
            SLOT_SHOW:  if (wrap)                state_d = SLOT_GUARD;
            default:                             state_d = SLOT_GUARD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            state_q <= SLOT_GUARD;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign cnt      = cnt_q;
    assign in_guard = (state_q == SLOT_GUARD);

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed 8-digit scan controller with frame-aligned double buffering.
// Outputs are registered or register-derived; load is always accepted (last value wins).
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input logic          clk,
    input logic          rst,
    display_scan_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(PRESCALE);

    logic [CNT_W-1:0] slot_cnt;
    logic             slot_wrap;
    logic             slot_in_guard;

    logic [SEL_W-1:0] sel_q, sel_d;
    logic [VAL_W-1:0] active_q, active_d;
    logic [VAL_W-1:0] shadow_q, shadow_d;
    logic             pending_q, pending_d;
    logic             frame_done_q, frame_done_d;
    logic             blank_lz_q, blank_lz_d;
    logic             boundary;

    slot_timer #(
        .PRESCALE     (PRESCALE),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk      (clk),
        .rst      (rst),
        .cnt      (slot_cnt),
        .wrap     (slot_wrap),
        .in_guard (slot_in_guard)
    );

    always_comb begin
        boundary     = slot_wrap && (sel_q == SEL_W'(DIGITS - 1));
        sel_d        = slot_wrap ? sel_q + 1'b1 : sel_q;
        frame_done_d = boundary;
        blank_lz_d   = bus.blank_lz;
        active_d     = active_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;

        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end

        // A load landing on the boundary edge bypasses the shadow entirely.
        if (bus.load) begin
            if (boundary) begin
                active_d  = bus.value_in;
                pending_d = 1'b0;
            end else begin
                shadow_d  = bus.value_in;
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            frame_done_q <= 1'b0;
            blank_lz_q   <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            frame_done_q <= frame_done_d;
            blank_lz_q   <= blank_lz_d;
        end
    end

    // The GUARD/SHOW tracker must agree with the raw slot count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (slot_in_guard == (slot_cnt < CNT_W'(BLANK_CYCLES)));
        end
    end

    assign bus.sel        = sel_q;
    assign bus.nibble     = digit_nibble(active_q, sel_q);
    assign bus.sel_en     = !slot_in_guard && !(blank_lz_q && lz_blanked(active_q, sel_q));
    assign bus.pending    = pending_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench: small-prescale instance for function, board-prescale instance for timing.
module tb_display_scan_ctrl;
    import display_scan_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1;
    logic rst_b = 1'b1;

    display_scan_ctrl_if bus_a ();
    display_scan_ctrl_if bus_b ();

    display_scan_ctrl #(.PRESCALE(4), .BLANK_CYCLES(1)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    display_scan_ctrl #(.PRESCALE(1000), .BLANK_CYCLES(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic        sb_pend = 1'b0;
    logic [31:0] shown   = '0;
    logic [2:0]  prev_sel;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [3:0] nib_of(input logic [31:0] v, input int k);
        logic [31:0] s;
        s = (v >> (28 - 4 * k)) & 32'hF;
        return s[3:0];
    endfunction

    // Enable expected for digit k: blanking hides digits left of the first non-zero one.
    function automatic logic en_of(input logic [31:0] v, input int k, input logic blz);
        int lz;
        lz = 0;
        while (lz < 8 && nib_of(v, lz) == 4'h0) lz++;
        if (!blz || k == 7) return 1'b1;
        return !(k < lz);
    endfunction

    task automatic do_load(input logic [31:0] v);
        if (sb_pend) exp_q[exp_q.size() - 1] = v;
        else         exp_q.push_back(v);
        sb_pend = 1'b1;
    endtask

    // Checks one full frame of dut_a cycle by cycle, optionally loading at frame indices la1/la2.
    task automatic check_frame(input bit first, input bit blz,
                               input int la1, input logic [31:0] v1,
                               input int la2, input logic [31:0] v2);
        logic pend;
        pend = 1'b0;
        if (!first && sb_pend) begin
            shown   = exp_q.pop_front();
            sb_pend = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            chk("sel",        32'(bus_a.sel),        32'(i / 4));
            chk("nibble",     32'(bus_a.nibble),     32'(nib_of(shown, i / 4)));
            chk("sel_en",     32'(bus_a.sel_en),     32'((i % 4 >= 1) && en_of(shown, i / 4, blz)));
            chk("pending",    32'(bus_a.pending),    32'(pend));
            chk("frame_done", 32'(bus_a.frame_done), 32'(i == 0 && !first));
            bus_a.blank_lz = blz;
            if (i == la1) begin
                bus_a.load = 1'b1; bus_a.value_in = v1; do_load(v1);
                if (i < 31) pend = 1'b1;
            end else if (i == la2) begin
                bus_a.load = 1'b1; bus_a.value_in = v2; do_load(v2);
                if (i < 31) pend = 1'b1;
            end else begin
                bus_a.load = 1'b0;
            end
            tick();
        end
        bus_a.load = 1'b0;
    endtask

    initial begin
        bus_a.load = 1'b0; bus_a.value_in = '0; bus_a.blank_lz = 1'b0;
        bus_b.load = 1'b0; bus_b.value_in = '0; bus_b.blank_lz = 1'b0;

        tick(); tick();
        rst_a = 1'b0;

        chk("rst_sel",        32'(bus_a.sel),        32'd0);
        chk("rst_sel_en",     32'(bus_a.sel_en),     32'd0);
        chk("rst_nibble",     32'(bus_a.nibble),     32'd0);
        chk("rst_pending",    32'(bus_a.pending),    32'd0);
        chk("rst_frame_done", 32'(bus_a.frame_done), 32'd0);

        check_frame(1, 0, -1, '0, -1, '0);
        check_frame(0, 0, 13, 32'h1234ABCD, -1, '0);
        check_frame(0, 1, 10, 32'h00000F00, -1, '0);
        check_frame(0, 1, 5,  32'h00000000, -1, '0);
        check_frame(0, 1, 4,  32'h11111111, 20, 32'h22222222);
        check_frame(0, 0, 31, 32'h5A5A5A5A, -1, '0);
        check_frame(0, 0, -1, '0, -1, '0);

        // Mid-frame reset with a value still pending at digit 5.
        for (int i = 0; i < 20; i++) begin
            if (i == 6) begin
                bus_a.load = 1'b1; bus_a.value_in = 32'hCAFEF00D;
            end else begin
                bus_a.load = 1'b0;
            end
            tick();
        end
        chk("pre_rst_sel",     32'(bus_a.sel),     32'd5);
        chk("pre_rst_pending", 32'(bus_a.pending), 32'd1);
        chk("pre_rst_nibble",  32'(bus_a.nibble),  32'(nib_of(shown, 5)));
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("mid_rst_sel",        32'(bus_a.sel),        32'd0);
        chk("mid_rst_sel_en",     32'(bus_a.sel_en),     32'd0);
        chk("mid_rst_pending",    32'(bus_a.pending),    32'd0);
        chk("mid_rst_nibble",     32'(bus_a.nibble),     32'd0);
        chk("mid_rst_frame_done", 32'(bus_a.frame_done), 32'd0);
        exp_q.delete();
        sb_pend = 1'b0;
        shown   = '0;
        check_frame(1, 0, -1, '0, -1, '0);
        check_frame(0, 0, -1, '0, -1, '0);

        // Board prescale: 1000-cycle slots, 4-cycle guard, three frames.
        rst_b = 1'b0;
        prev_sel = 3'd0;
        for (int n = 0; n <= 24000; n++) begin
            chk("b_sel",        32'(bus_b.sel),        32'((n / 1000) % 8));
            chk("b_sel_en",     32'(bus_b.sel_en),     32'(n % 1000 >= 4));
            chk("b_frame_done", 32'(bus_b.frame_done), 32'(n > 0 && n % 8000 == 0));
            if (n > 0 && bus_b.sel != prev_sel) begin
                chk("b_en_at_sel_change", 32'(bus_b.sel_en), 32'd0);
            end
            prev_sel = bus_b.sel;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
